// File: rtl/convertidor_binario_bcd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with a
// start/busy/done handshake; digit outputs update only when a conversion completes.
module convertidor_binario_bcd #(
  parameter int ANCHO_BINARIO = 14,
  parameter int LIMITE        = 9999
) (
  input  logic                     i_Reloj,
  input  logic                     i_Reset,
  input  logic                     i_Inicio,
  input  logic [ANCHO_BINARIO-1:0] i_Binario,
  output logic [3:0]               o_Datos_0,
  output logic [3:0]               o_Datos_1,
  output logic [3:0]               o_Datos_2,
  output logic [3:0]               o_Datos_3,
  output logic                     o_Ocupado,
  output logic                     o_Listo,
  output logic                     o_Desborde
);

  localparam int CW = $clog2(ANCHO_BINARIO + 1);

  typedef enum logic [1:0] {
    REPOSO,
    DESPLAZA,
    TERMINA
  } estado_t;

  estado_t                  estado_reg, estado_next;
  logic [ANCHO_BINARIO-1:0] binario_reg, binario_next;
  logic [15:0]              acum_reg, acum_next, acum_ajustado;
  logic [CW-1:0]            contador_reg, contador_next;
  logic                     desborde_pend_reg, desborde_pend_next;
  logic [15:0]              datos_reg, datos_next;
  logic                     ocupado_reg, ocupado_next;
  logic                     listo_reg, listo_next;
  logic                     desborde_reg, desborde_next;

  // Add-3 correction applied to every BCD nibble before each shift
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ajuste
      assign acum_ajustado[4*gi +: 4] = (acum_reg[4*gi +: 4] >= 4'd5)
                                        ? acum_reg[4*gi +: 4] + 4'd3
                                        : acum_reg[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge i_Reloj) begin
    if (i_Reset) begin
      estado_reg        <= REPOSO;
      binario_reg       <= '0;
      acum_reg          <= '0;
      contador_reg      <= '0;
      desborde_pend_reg <= 1'b0;
      datos_reg         <= '0;
      ocupado_reg       <= 1'b0;
      listo_reg         <= 1'b0;
      desborde_reg      <= 1'b0;
    end else begin
      estado_reg        <= estado_next;
      binario_reg       <= binario_next;
      acum_reg          <= acum_next;
      contador_reg      <= contador_next;
      desborde_pend_reg <= desborde_pend_next;
      datos_reg         <= datos_next;
      ocupado_reg       <= ocupado_next;
      listo_reg         <= listo_next;
      desborde_reg      <= desborde_next;
    end
  end

  always_comb begin
    estado_next        = estado_reg;
    binario_next       = binario_reg;
    acum_next          = acum_reg;
    contador_next      = contador_reg;
    desborde_pend_next = desborde_pend_reg;
    datos_next         = datos_reg;
    ocupado_next       = ocupado_reg;
    listo_next         = 1'b0;
    desborde_next      = desborde_reg;

    case (estado_reg)
      REPOSO: begin
        if (i_Inicio) begin
          binario_next       = i_Binario;
          acum_next          = '0;
          contador_next      = CW'(ANCHO_BINARIO);
          // Overflow is decided on the captured value; the live input may change later
          desborde_pend_next = (32'(i_Binario) > 32'(LIMITE));
          ocupado_next       = 1'b1;
          estado_next        = DESPLAZA;
        end
      end
      DESPLAZA: begin
        acum_next     = {acum_ajustado[14:0], binario_reg[ANCHO_BINARIO-1]};
        binario_next  = binario_reg << 1;
        contador_next = contador_reg - CW'(1);
        if (contador_reg == CW'(1)) begin
          estado_next = TERMINA;
        end
      end
      TERMINA: begin
        datos_next    = desborde_pend_reg ? 16'h9999 : acum_reg;
        desborde_next = desborde_pend_reg;
        listo_next    = 1'b1;
        ocupado_next  = 1'b0;
        estado_next   = REPOSO;
      end
      default: begin
        estado_next  = REPOSO;
        ocupado_next = 1'b0;
      end
    endcase
  end

  assign o_Datos_0  = datos_reg[3:0];
  assign o_Datos_1  = datos_reg[7:4];
  assign o_Datos_2  = datos_reg[11:8];
  assign o_Datos_3  = datos_reg[15:12];
  assign o_Ocupado  = ocupado_reg;
  assign o_Listo    = listo_reg;
  assign o_Desborde = desborde_reg;

endmodule

// File: tb/tb_convertidor_binario_bcd.sv
// Self-checking bench for convertidor_binario_bcd: vector table, hand-written
// corner sequences and randomized back-to-back conversions against a decimal model.
module tb_convertidor_binario_bcd;

  localparam int ANCHO   = 14;
  localparam int LATENCY = ANCHO + 1;

  logic             i_Reloj;
  logic             i_Reset;
  logic             i_Inicio;
  logic [ANCHO-1:0] i_Binario;
  logic [3:0]       o_Datos_0, o_Datos_1, o_Datos_2, o_Datos_3;
  logic             o_Ocupado, o_Listo, o_Desborde;

  int tests_run = 0;
  int tests_failed = 0;

  convertidor_binario_bcd #(.ANCHO_BINARIO(ANCHO), .LIMITE(9999)) dut (
    .i_Reloj   (i_Reloj),
    .i_Reset   (i_Reset),
    .i_Inicio  (i_Inicio),
    .i_Binario (i_Binario),
    .o_Datos_0 (o_Datos_0),
    .o_Datos_1 (o_Datos_1),
    .o_Datos_2 (o_Datos_2),
    .o_Datos_3 (o_Datos_3),
    .o_Ocupado (o_Ocupado),
    .o_Listo   (o_Listo),
    .o_Desborde(o_Desborde)
  );

  initial i_Reloj = 1'b0;
  always #5 i_Reloj = ~i_Reloj;

  typedef struct {
    int          bin;
    logic [15:0] bcd;
    logic        desb;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [15:0] digits();
    return {o_Datos_3, o_Datos_2, o_Datos_1, o_Datos_0};
  endfunction

  // Reference: saturate, then split into decimal digits with plain arithmetic
  function automatic logic [15:0] ref_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic tick();
    @(posedge i_Reloj);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts a conversion from REPOSO and waits for o_Listo; returns on the o_Listo cycle
  task automatic convert(input int v, input logic [15:0] exp_bcd, input logic exp_desb);
    logic [15:0] prev;
    int          edges;
    bit          stable, busy;
    prev      = digits();
    i_Binario = ANCHO'(v);
    i_Inicio  = 1'b1;
    tick();
    i_Inicio  = 1'b0;
    chk("ocupado_after_accept", 32'(o_Ocupado), 32'd1);
    chk("listo_single_pulse", 32'(o_Listo), 32'd0);
    edges  = 0;
    stable = 1'b1;
    busy   = 1'b1;
    while (!o_Listo && edges < 40) begin
      if (digits() !== prev) stable = 1'b0;
      if (o_Ocupado !== 1'b1) busy = 1'b0;
      i_Binario = ANCHO'($urandom);
      tick();
      edges++;
    end
    chk("latency", 32'(edges), 32'(LATENCY));
    chk("no_intermediate_digits", 32'(stable), 32'd1);
    chk("ocupado_held", 32'(busy), 32'd1);
    chk("digits", 32'(digits()), 32'(exp_bcd));
    chk("desborde", 32'(o_Desborde), 32'(exp_desb));
    chk("ocupado_done", 32'(o_Ocupado), 32'd0);
    $display("[TB] conv %0d -> %h desb=%0b latency=%0d", v, digits(), o_Desborde, edges);
  endtask

  initial begin
    int          listo_count, listo_edge, v;
    logic [15:0] snap;

    vecs[0] = '{1234,  16'h1234, 1'b0};
    vecs[1] = '{0,     16'h0000, 1'b0};
    vecs[2] = '{9999,  16'h9999, 1'b0};
    vecs[3] = '{10,    16'h0010, 1'b0};
    vecs[4] = '{10000, 16'h9999, 1'b1};
    vecs[5] = '{16383, 16'h9999, 1'b1};
    vecs[6] = '{42,    16'h0042, 1'b0};

    // Reset with start held high
    i_Reset = 1'b1; i_Inicio = 1'b1; i_Binario = ANCHO'(1234);
    tick(); tick();
    chk("rst_digits", 32'(digits()), 32'd0);
    chk("rst_ocupado", 32'(o_Ocupado), 32'd0);
    chk("rst_listo", 32'(o_Listo), 32'd0);
    chk("rst_desborde", 32'(o_Desborde), 32'd0);
    i_Reset = 1'b0; i_Inicio = 1'b0;
    tick();
    chk("post_rst_idle", 32'(o_Ocupado), 32'd0);
    $display("[TB] reset checked");

    // Vector table, each conversion started on the previous o_Listo cycle
    for (int i = 0; i < 7; i++) convert(vecs[i].bin, vecs[i].bcd, vecs[i].desb);

    // Ignored start while busy and input changing mid-conversion
    tick();
    i_Binario = ANCHO'(5678); i_Inicio = 1'b1;
    tick();
    i_Inicio = 1'b0;
    listo_count = 0; listo_edge = -1; snap = 16'h0;
    for (int e = 1; e <= 30; e++) begin
      if (e == 4) i_Binario = ANCHO'(1111);
      if (e == 6) i_Inicio = 1'b1;
      tick();
      i_Inicio = 1'b0;
      if (o_Listo) begin
        listo_count++;
        if (listo_edge < 0) begin
          listo_edge = e;
          snap = digits();
        end
      end
    end
    chk("busy_start_listo_count", 32'(listo_count), 32'd1);
    chk("busy_start_latency", 32'(listo_edge), 32'(LATENCY));
    chk("busy_start_digits", 32'(snap), 32'h5678);
    $display("[TB] busy-start sequence listo=%0d at %0d digits=%h", listo_count, listo_edge, snap);

    // Reset in the middle of a conversion
    convert(4321, 16'h4321, 1'b0);
    tick();
    i_Binario = ANCHO'(8765); i_Inicio = 1'b1;
    tick();
    i_Inicio = 1'b0;
    for (int e = 1; e < 7; e++) tick();
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    chk("midrst_digits", 32'(digits()), 32'd0);
    chk("midrst_ocupado", 32'(o_Ocupado), 32'd0);
    listo_count = 0;
    for (int e = 0; e < 20; e++) begin
      if (o_Listo) listo_count++;
      tick();
    end
    chk("midrst_no_listo", 32'(listo_count), 32'd0);
    $display("[TB] mid-conversion reset checked");
    convert(8765, 16'h8765, 1'b0);

    // Randomized back-to-back conversions against the decimal model
    for (int i = 0; i < 25; i++) begin
      v = int'($urandom_range(0, (1 << ANCHO) - 1));
      if (i % 5 == 0) v = int'($urandom_range(9990, 10010));
      convert(v, ref_bcd(v), v > 9999);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/convertidor_binario_bcd.md
Name: convertidor_binario_bcd

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm, one bit per clock. Sits directly upstream of the 4-digit 7-segment display controller. Its four registered BCD digits drive that controller's i_Datos_0..i_Datos_3 inputs. A start/busy/done handshake lets a counter or sensor stage request a new value at any time. The digit outputs change only on completion, so the display never shows intermediate values.

Parameters:
ANCHO_BINARIO, 14, width of binary input; legal range 1..16.
LIMITE, 9999, largest displayable value; inputs above it saturate.

Ports:
i_Reloj  input  1  system clock; all logic on rising edge.
i_Reset  input  1  synchronous, active-high reset.
i_Inicio  input  1  start request; sampled only in REPOSO.
i_Binario  input  ANCHO_BINARIO  unsigned value to convert; captured on the accepting edge.
o_Datos_0  output  4  BCD units digit.
o_Datos_1  output  4  BCD tens digit.
o_Datos_2  output  4  BCD hundreds digit.
o_Datos_3  output  4  BCD thousands digit.
o_Ocupado  output  1  high while a conversion is in progress.
o_Listo  output  1  one-cycle pulse when new digits are valid.
o_Desborde  output  1  last accepted input exceeded LIMITE; held until the next completion.

Behaviour:
- Reset (sampled at a rising edge with i_Reset=1):
  - All o_Datos_* = 0; o_Ocupado = 0, o_Listo = 0, o_Desborde = 0.
  - FSM = REPOSO; internal shift register and iteration counter cleared.
  - Reset overrides every other input, including in the middle of a conversion. The conversion is abandoned and no o_Listo is generated.
- FSM states: REPOSO, DESPLAZA, TERMINA.
- REPOSO:
  - If i_Inicio=1 at an edge (call it E0): capture i_Binario into the shift register, clear the 16-bit BCD accumulator, set counter = ANCHO_BINARIO, go to DESPLAZA, set o_Ocupado=1.
  - Otherwise hold state.
- DESPLAZA: on each edge,
  - For each 4-bit accumulator nibble ≥5, add 3 to that nibble.
  - Then shift {accumulator, binary register} left by 1.
  - Decrement the counter.
  - The edge that performs the last iteration (E_ANCHO_BINARIO) moves to TERMINA.
  - Bits shifted out of the thousands nibble are discarded. The lower four digits remain correct modulo 10000.
- TERMINA: on the next edge (E_ANCHO_BINARIO+1):
  - If the captured input ≤ LIMITE: copy the accumulator nibbles to o_Datos_0..3 and set o_Desborde=0.
  - Otherwise: drive all four digits to 9 and set o_Desborde=1.
  - Set o_Listo=1 (for exactly one cycle), o_Ocupado=0, and return to REPOSO.
  - The overflow compare uses the captured value, not the live i_Binario.
- Latency: o_Listo is high in the cycle following edge E0 + ANCHO_BINARIO + 1. With the default width this is 15 edges after the accepting edge.
- i_Inicio while o_Ocupado=1 is ignored (no queueing). i_Binario may change freely after E0.
- i_Inicio=1 in the cycle where o_Listo=1: the FSM is already in REPOSO, so the request is accepted and the back-to-back conversion starts. The previous digits stay on the outputs until the new completion.
- i_Inicio held high continuously produces a conversion every ANCHO_BINARIO+2 cycles.
- All outputs are registered; none is combinational from the inputs.

Test Plan:
1. Assert i_Reset for 2 cycles with i_Inicio=1 → all digits 0, o_Ocupado=0, o_Listo=0, o_Desborde=0; no conversion starts.
2. i_Binario=1234, 1-cycle i_Inicio → o_Ocupado high for 15 cycles; o_Listo pulses once at E0+15; digits 3..0 = 1,2,3,4; o_Desborde=0.
3. Convert 0, then 9999, then 10 (each back-to-back on the o_Listo cycle) → digits 0000, 9999, 0010; each o_Listo exactly 15 edges after its accepting edge; outputs never show intermediate values.
4. i_Binario=10000, then 16383 → digits 9,9,9,9 and o_Desborde=1. A following conversion of 42 → digits 0,0,4,2 and o_Desborde=0.
5. Start 5678, pulse i_Inicio with 1111 at E0+5, and change i_Binario at E0+3 → result 5678 at E0+15; no second o_Listo.
6. Complete 4321, then start 8765 and assert i_Reset at E0+7 → digits reset to 0, no o_Listo; a fresh start of 8765 then completes normally.
